fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding and fetch constants.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  localparam int unsigned PC_INC   = 4;
  localparam logic [63:0] NOP_WORD = 64'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, ir} entries; flush empties it in one edge.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       n_rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: empty entries are never presented downstream.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding memory requests feeding a decode queue.
//   state | meaning
//   IDLE  | no request outstanding; may issue one
//   WAIT  | one request outstanding; its response is pushed
//   DROP  | outstanding response belongs to a flushed path; discard it
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                    clk_i,
  input  logic                    n_rst_i,
  output logic                    imem_req_o,
  output logic [XLEN-1:0]         imem_addr_o,
  input  logic                    imem_ack_i,
  input  logic [XLEN-1:0]         imem_data_i,
  input  logic                    ID_stall_i,
  input  logic                    MEM_do_branch_i,
  input  logic [XLEN-1:0]         MEM_pc_branched_i,
  output logic                    IFID_valid_o,
  output logic [XLEN-1:0]         IFID_pc_o,
  output logic [XLEN-1:0]         IFID_ir_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  fq_state_e              state_q;
  fq_state_e              state_d;
  logic [XLEN-1:0]        fetch_pc_q;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [2*XLEN-1:0]      fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^MEM_pc_branched_i[1:0];

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) state_q <= FQ_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FQ_IDLE: if (imem_req_o) state_d = FQ_WAIT;
      FQ_WAIT: begin
        if (imem_ack_i)           state_d = FQ_IDLE;
        else if (MEM_do_branch_i) state_d = FQ_DROP;
      end
      FQ_DROP: if (imem_ack_i) state_d = FQ_IDLE;
      default: state_d = FQ_IDLE;
    endcase
  end

  // Requests are held off during reset so nothing is issued before release.
  always_comb begin
    imem_req_o = n_rst_i && (state_q == FQ_IDLE) && !fifo_full && !MEM_do_branch_i;
    push       = (state_q == FQ_WAIT) && imem_ack_i && !MEM_do_branch_i;
    pop        = !fifo_empty && !ID_stall_i && !MEM_do_branch_i;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      fetch_pc_q <= RESET_PC;
    end else if (MEM_do_branch_i) begin
      fetch_pc_q <= {MEM_pc_branched_i[XLEN-1:2], 2'b00};
    end else if (push) begin
      fetch_pc_q <= fetch_pc_q + XLEN'(PC_INC);
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .n_rst_i (n_rst_i),
    .push    (push),
    .pop     (pop),
    .flush   (MEM_do_branch_i),
    .wdata   ({fetch_pc_q, imem_data_i}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  assign imem_addr_o  = fetch_pc_q;
  assign IFID_valid_o = !fifo_empty;
  assign IFID_pc_o    = fifo_empty ? XLEN'(NOP_WORD) : fifo_head[2*XLEN-1:XLEN];
  assign IFID_ir_o    = fifo_empty ? XLEN'(NOP_WORD) : fifo_head[XLEN-1:0];
  assign count_o      = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference of the fetch rules.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = '0;
  logic        ID_stall_i = 1'b0;
  logic        MEM_do_branch_i = 1'b0;
  logic [31:0] MEM_pc_branched_i = '0;
  logic        IFID_valid_o;
  logic [31:0] IFID_pc_o;
  logic [31:0] IFID_ir_o;
  logic [2:0]  count_o;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i             (clk_i),
    .n_rst_i           (n_rst_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ack_i        (imem_ack_i),
    .imem_data_i       (imem_data_i),
    .ID_stall_i        (ID_stall_i),
    .MEM_do_branch_i   (MEM_do_branch_i),
    .MEM_pc_branched_i (MEM_pc_branched_i),
    .IFID_valid_o      (IFID_valid_o),
    .IFID_pc_o         (IFID_pc_o),
    .IFID_ir_o         (IFID_ir_o),
    .count_o           (count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // reference: queued {pc, ir}, next fetch pc, outstanding request, stale flag
  logic [63:0] m_q[$];
  logic [31:0] m_pc    = RESET_PC;
  bit          m_out   = 0;
  bit          m_stale = 0;

  // memory responder
  bit          mem_busy  = 0;
  int          mem_cnt   = 0;
  logic [31:0] mem_word  = '0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          spur_pct  = 0;
  bit          force_ack = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic run_cycle(input logic stall, input logic br, input logic [31:0] tgt);
    logic        exp_req;
    logic        pop;
    logic        ack;
    logic [31:0] data;
    logic [31:0] exp_pc;
    logic [31:0] exp_ir;
    @(negedge clk_i);
    imem_ack_i  = 1'b0;
    imem_data_i = $urandom;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word;
        mem_busy    = 0;
      end else begin
        mem_cnt--;
      end
    end else if (force_ack || ($urandom_range(0, 99) < spur_pct)) begin
      imem_ack_i = 1'b1;
      force_ack  = 0;
    end
    ID_stall_i        = stall;
    MEM_do_branch_i   = br;
    MEM_pc_branched_i = tgt;
    #1;
    exp_req = !m_out && (m_q.size() < DEPTH) && !br;
    exp_pc  = '0;
    exp_ir  = '0;
    if (m_q.size() != 0) begin
      exp_pc = m_q[0][63:32];
      exp_ir = m_q[0][31:0];
    end
    check_val("imem_req", imem_req_o, exp_req);
    if (exp_req) check_val("imem_addr", imem_addr_o, m_pc);
    check_val("ifid_valid", IFID_valid_o, m_q.size() != 0);
    check_val("ifid_pc", IFID_pc_o, exp_pc);
    check_val("ifid_ir", IFID_ir_o, exp_ir);
    check_val("count", count_o, m_q.size());
    if (imem_req_o) begin
      mem_busy = 1;
      mem_cnt  = $urandom_range(lat_min, lat_max) - 1;
      mem_word = $urandom;
    end
    ack  = imem_ack_i;
    data = imem_data_i;
    pop  = (m_q.size() != 0) && !stall && !br;
    if (pop) void'(m_q.pop_front());
    if (br) begin
      m_q.delete();
      if (m_out && ack) m_out = 0;
      m_stale = m_out;
      m_pc    = {tgt[31:2], 2'b00};
    end else if (m_out && ack) begin
      if (!m_stale) begin
        m_q.push_back({m_pc, data});
        m_pc = m_pc + 32'd4;
      end
      m_out   = 0;
      m_stale = 0;
    end
    if (exp_req) m_out = 1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2;
    n_rst_i         = 1'b0;
    imem_ack_i      = 1'b0;
    ID_stall_i      = 1'b0;
    MEM_do_branch_i = 1'b0;
    #1;
    check_val("rst_req", imem_req_o, 1'b0);
    check_val("rst_valid", IFID_valid_o, 1'b0);
    check_val("rst_pc", IFID_pc_o, 32'h0);
    check_val("rst_ir", IFID_ir_o, 32'h0);
    check_val("rst_count", count_o, 3'd0);
    check_val("rst_addr", imem_addr_o, RESET_PC);
    m_q.delete();
    m_pc     = RESET_PC;
    m_out    = 0;
    m_stale  = 0;
    mem_busy = 0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #2 n_rst_i = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // reset, then streaming with zero-wait memory
    do_reset();
    run_cycle(0, 0, '0);
    check_val("first_addr", imem_addr_o, RESET_PC);
    repeat (30) run_cycle(0, 0, '0);

    // decode stall fills the queue, release drains it in order
    do_reset();
    repeat (10) run_cycle(1, 0, '0);
    check_val("stall_full", count_o, 3'd4);
    repeat (20) run_cycle(0, 0, '0);

    // redirect while a slow response is outstanding
    lat_min = 4; lat_max = 4;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_out && !m_stale && mem_busy) begin found = 1; break; end
      run_cycle(0, 0, '0);
    end
    check_val("find_wait", found, 1'b1);
    run_cycle(0, 1, 32'h0000_0100);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      run_cycle(0, 0, '0);
      if (IFID_valid_o) begin
        check_val("redir_first_pc", IFID_pc_o, 32'h100);
        found = 1;
        break;
      end
    end
    check_val("redir_seen", found, 1'b1);

    // redirect in the same cycle as an ack and a pop
    lat_min = 1; lat_max = 1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_busy && mem_cnt == 0 && m_q.size() > 0) begin found = 1; break; end
      run_cycle(1, 0, '0);
    end
    check_val("find_ack_pop", found, 1'b1);
    run_cycle(0, 1, 32'h0000_0200);
    run_cycle(0, 0, '0);
    check_val("ack_redir_count", count_o, 3'd0);
    check_val("ack_redir_addr", imem_addr_o, 32'h200);
    check_val("ack_redir_req", imem_req_o, 1'b1);

    // unaligned target is aligned; fetch pc wraps at the top of the space
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (!m_out) begin found = 1; break; end
      run_cycle(0, 0, '0);
    end
    check_val("find_idle", found, 1'b1);
    run_cycle(0, 1, 32'h0000_0103);
    run_cycle(0, 0, '0);
    check_val("align_addr", imem_addr_o, 32'h100);
    run_cycle(0, 1, 32'hFFFF_FFF8);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      run_cycle(0, 0, '0);
      if (IFID_valid_o && IFID_pc_o == 32'h0) begin found = 1; break; end
    end
    check_val("wrap_seen", found, 1'b1);

    // reset while waiting with three entries queued; stale ack afterwards
    lat_min = 1; lat_max = 3;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_q.size() == 3 && m_out) begin found = 1; break; end
      run_cycle(1, 0, '0);
    end
    check_val("find_wait3", found, 1'b1);
    do_reset();
    force_ack = 1;
    run_cycle(0, 0, '0);
    check_val("post_rst_addr", imem_addr_o, RESET_PC);
    repeat (10) run_cycle(0, 0, '0);

    // randomized traffic
    spur_pct = 10;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tgt;
      if (i % 100 == 0) lat_max = $urandom_range(1, 5);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, tgt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
